shuffle_loader_nbeat: RTL and testbench

- Parametrised successor loader between the explode stage and the shuffle stage.
- Accepts one EXPLODE_WIDTH block plus nonce from explode over a level (four-phase) handshake that tolerates the clock-domain crossing.
- Buffers up to BUF_DEPTH blocks and emits each block as NBEATS interleaved beats over a full valid/ready stream.
- Every beat is back-pressured by shuffle, not only the first; explode may deliver the next block while the current one drains.

---
 rtl/shuffle_loader_nbeat_pkg.sv | 31 +++
 rtl/shuffle_loader_nbeat_if.sv | 49 ++++
 rtl/shuffle_loader_buf.sv | 65 ++++++
 rtl/shuffle_loader_nbeat.sv | 111 +++++++++++
 tb/tb_shuffle_loader_nbeat.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shuffle_loader_nbeat_pkg.sv
// Shared definitions for the shuffle loader: ingress state encodings,
// beat slicing helpers and the stall-counter width.
package shuffle_pkg;

  // Ingress four-phase handshake states
  localparam logic [0:0] ING_WAIT = 1'b0;
  localparam logic [0:0] ING_ACK  = 1'b1;

  // Width of the optional back-pressure stall counter
  localparam int STALL_CNT_W = 16;

  // Bit offsets of the two lanes that make up one beat
  typedef struct packed {
    int lo_lsb;
    int hi_lsb;
  } slice_t;

  function automatic int lane_width(input int explode_width, input int nbeats);
    return explode_width / (2 * nbeats);
  endfunction

  // Beat k takes lane k (placed in the MSB half) and lane NBEATS+k (LSB half)
  function automatic slice_t beat_slice(input int explode_width, input int nbeats,
                                        input int k);
    slice_t s;
    s.lo_lsb = k * lane_width(explode_width, nbeats);
    s.hi_lsb = (nbeats + k) * lane_width(explode_width, nbeats);
    return s;
  endfunction

endpackage

// File: rtl/shuffle_loader_nbeat_if.sv
// Bus bundle between explode, the loader and shuffle.
// Optional o_stall_cnt appears when SHUFFLE_LOADER_STALL_CNT_EN is defined.
interface shuffle_loader_nbeat_if #(
  parameter int NONCE_WIDTH   = 7,
  parameter int EXPLODE_WIDTH = 512,
  parameter int NBEATS        = 4
);
  import shuffle_pkg::*;

  localparam int BEAT_W = EXPLODE_WIDTH / NBEATS;
  localparam int IDX_W  = $clog2(NBEATS);

  logic                     i_ex_valid;
  logic                     o_ex_handshake;
  logic [EXPLODE_WIDTH-1:0] i_ex_data;
  logic [NONCE_WIDTH-1:0]   i_nonce;
  logic                     o_sh_valid;
  logic                     i_sh_ready;
  logic [BEAT_W-1:0]        o_sh_data;
  logic [NONCE_WIDTH-1:0]   o_nonce;
  logic [IDX_W-1:0]         o_beat;
  logic                     o_last;
`ifdef SHUFFLE_LOADER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0]   o_stall_cnt;

  modport slave (
    input  i_ex_valid, i_ex_data, i_nonce, i_sh_ready,
    output o_ex_handshake, o_sh_valid, o_sh_data, o_nonce, o_beat, o_last,
           o_stall_cnt
  );

  modport master (
    output i_ex_valid, i_ex_data, i_nonce, i_sh_ready,
    input  o_ex_handshake, o_sh_valid, o_sh_data, o_nonce, o_beat, o_last,
           o_stall_cnt
  );
`else
  modport slave (
    input  i_ex_valid, i_ex_data, i_nonce, i_sh_ready,
    output o_ex_handshake, o_sh_valid, o_sh_data, o_nonce, o_beat, o_last
  );

  modport master (
    output i_ex_valid, i_ex_data, i_nonce, i_sh_ready,
    input  o_ex_handshake, o_sh_valid, o_sh_data, o_nonce, o_beat, o_last
  );
`endif

endinterface

// File: rtl/shuffle_loader_buf.sv
// Small FIFO of {block, nonce} entries (depth 1 or 2). A push into a full
// FIFO is accepted when a pop happens in the same cycle.
module shuffle_loader_buf #(
  parameter int DATA_W  = 512,
  parameter int NONCE_W = 7,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [DATA_W-1:0]  push_data,
  input  logic [NONCE_W-1:0] push_nonce,
  input  logic               pop,
  output logic [CNT_W-1:0]   count,
  output logic [DATA_W-1:0]  head_data,
  output logic [NONCE_W-1:0] head_nonce
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0]  mem_data  [DEPTH];
  logic [NONCE_W-1:0] mem_nonce [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_pop;
  logic               do_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop     = pop && (count != '0);
  assign do_push    = push && ((count < CNT_W'(DEPTH)) || do_pop);
  assign head_data  = mem_data[rd_ptr];
  assign head_nonce = mem_nonce[rd_ptr];

  // Storage, pointers and occupancy; contents cleared so nothing is ever X
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i]  <= '0;
        mem_nonce[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem_data[wr_ptr]  <= push_data;
        mem_nonce[wr_ptr] <= push_nonce;
        wr_ptr            <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shuffle_loader_nbeat.sv
// Loader between explode and shuffle: captures blocks over a four-phase
// handshake, buffers them and streams each as NBEATS interleaved beats.
// Optional feature macro: SHUFFLE_LOADER_STALL_CNT_EN (adds o_stall_cnt).
module shuffle_loader_nbeat #(
  parameter int NONCE_WIDTH   = 7,
  parameter int EXPLODE_WIDTH = 512,
  parameter int NBEATS        = 4,
  parameter int BUF_DEPTH     = 2
) (
  input logic                    clk,
  input logic                    rst,
  shuffle_loader_nbeat_if.slave  bus
);
  import shuffle_pkg::*;

  localparam int L      = EXPLODE_WIDTH / (2 * NBEATS);
  localparam int BEAT_W = EXPLODE_WIDTH / NBEATS;
  localparam int IDX_W  = $clog2(NBEATS);
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);

  logic [0:0]               ing_state;
  logic [CNT_W-1:0]         count;
  logic [EXPLODE_WIDTH-1:0] head_data;
  logic [NONCE_WIDTH-1:0]   head_nonce;
  logic [IDX_W-1:0]         beat;
  logic                     sh_valid;
  logic                     last;
  logic                     fire;
  logic                     push;
  logic                     pop;
  logic [BEAT_W-1:0]        beat_data;
  slice_t                   sl;

  assign sh_valid = (count != '0);
  assign last     = sh_valid && (beat == IDX_W'(NBEATS - 1));
  assign fire     = sh_valid && bus.i_sh_ready;
  assign pop      = fire && last;
  assign push     = (ing_state == ING_WAIT) && bus.i_ex_valid &&
                    ((count < CNT_W'(BUF_DEPTH)) || pop);

  shuffle_loader_buf #(
    .DATA_W  (EXPLODE_WIDTH),
    .NONCE_W (NONCE_WIDTH),
    .DEPTH   (BUF_DEPTH),
    .CNT_W   (CNT_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (bus.i_ex_data),
    .push_nonce (bus.i_nonce),
    .pop        (pop),
    .count      (count),
    .head_data  (head_data),
    .head_nonce (head_nonce)
  );

  // Ingress: one capture per valid pulse, acknowledge held until valid drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ing_state <= ING_WAIT;
    end else begin
      case (ing_state)
        ING_WAIT: if (push)           ing_state <= ING_ACK;
        ING_ACK:  if (!bus.i_ex_valid) ing_state <= ING_WAIT;
        default:                      ing_state <= ING_WAIT;
      endcase
    end
  end

  // Egress beat counter: advance on each transfer, wrap after the last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (fire) begin
      beat <= last ? '0 : beat + 1'b1;
    end
  end

  // Beat mux: low lane in the MSB half, partner lane in the LSB half
  always_comb begin
    sl        = beat_slice(EXPLODE_WIDTH, NBEATS, int'(beat));
    beat_data = '0;
    if (sh_valid) begin
      beat_data = {head_data[sl.lo_lsb +: L], head_data[sl.hi_lsb +: L]};
    end
  end

  assign bus.o_ex_handshake = (ing_state == ING_ACK);
  assign bus.o_sh_valid     = sh_valid;
  assign bus.o_sh_data      = beat_data;
  assign bus.o_nonce        = sh_valid ? head_nonce : '0;
  assign bus.o_beat         = beat;
  assign bus.o_last         = last;

`ifdef SHUFFLE_LOADER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt;

  // Saturating count of cycles a beat is offered but shuffle is not ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (sh_valid && !bus.i_sh_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_shuffle_loader_nbeat.sv
// Directed testbench for shuffle_loader_nbeat: a default (NBEATS=4) instance
// and an NBEATS=8 instance share clock and reset.
// Stall counter checks are built when SHUFFLE_LOADER_STALL_CNT_EN is defined.
module tb_shuffle_loader_nbeat;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  shuffle_loader_nbeat_if #(.NONCE_WIDTH(7), .EXPLODE_WIDTH(512), .NBEATS(4)) bus4 ();
  shuffle_loader_nbeat_if #(.NONCE_WIDTH(7), .EXPLODE_WIDTH(512), .NBEATS(8)) bus8 ();

  shuffle_loader_nbeat #(
    .NONCE_WIDTH(7), .EXPLODE_WIDTH(512), .NBEATS(4), .BUF_DEPTH(2)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  shuffle_loader_nbeat #(
    .NONCE_WIDTH(7), .EXPLODE_WIDTH(512), .NBEATS(8), .BUF_DEPTH(2)
  ) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  // Block whose 64-bit lane i holds base+i
  function automatic logic [511:0] mk_blk4(input logic [63:0] base);
    logic [511:0] b;
    for (int i = 0; i < 8; i++) b[i*64 +: 64] = base + 64'(i);
    return b;
  endfunction

  // Expected beat k of such a block: {lane k, lane k+4}
  function automatic logic [127:0] exp_beat4(input logic [63:0] base, input int k);
    logic [63:0] lo;
    logic [63:0] hi;
    lo = base + 64'(k);
    hi = base + 64'(k + 4);
    return {lo, hi};
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    bus4.i_ex_valid = 1'b0; bus4.i_ex_data = '0; bus4.i_nonce = '0; bus4.i_sh_ready = 1'b0;
    bus8.i_ex_valid = 1'b0; bus8.i_ex_data = '0; bus8.i_nonce = '0; bus8.i_sh_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Four-phase offer with bounded waits; ok=0 when no handshake was seen
  task automatic offer4(input logic [511:0] blk, input logic [6:0] nonce, output bit ok);
    bus4.i_ex_data  = blk;
    bus4.i_nonce    = nonce;
    bus4.i_ex_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus4.o_ex_handshake) begin
        ok = 1'b1;
        break;
      end
    end
    bus4.i_ex_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!bus4.o_ex_handshake) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus4.i_ex_valid = 1'b0; bus4.i_sh_ready = 1'b0;
    bus8.i_ex_valid = 1'b0; bus8.i_sh_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({bus4.o_sh_valid, bus4.o_ex_handshake, bus4.o_last} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000",
               {bus4.o_sh_valid, bus4.o_ex_handshake, bus4.o_last});
    end
    total++;
    if (bus4.o_sh_data !== 128'd0 || bus4.o_beat !== 2'd0 || bus4.o_nonce !== 7'd0) begin
      bad++;
      $display("FAIL reset_data: data=%h beat=%0d nonce=%h want 0",
               bus4.o_sh_data, bus4.o_beat, bus4.o_nonce);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus4.o_sh_valid !== 1'b0 || bus8.o_sh_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: valid4=%b valid8=%b want 0",
               bus4.o_sh_valid, bus8.o_sh_valid);
    end
  endtask

  task automatic test_single();
    bus4.i_ex_data  = mk_blk4(64'd0);
    bus4.i_nonce    = 7'h2A;
    bus4.i_ex_valid = 1'b1;
    bus4.i_sh_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total++;
        if (bus4.o_ex_handshake !== 1'b1) begin
          bad++;
          $display("FAIL single_handshake: got %b want 1", bus4.o_ex_handshake);
        end
        bus4.i_ex_valid = 1'b0;
      end
      total++;
      if (bus4.o_sh_valid !== 1'b1 || bus4.o_beat !== 2'(k) || bus4.o_sh_data !== exp_beat4(64'd0, k)) begin
        bad++;
        $display("FAIL single_beat%0d: valid=%b beat=%0d data=%h want 1 %0d %h",
                 k, bus4.o_sh_valid, bus4.o_beat, bus4.o_sh_data, k, exp_beat4(64'd0, k));
      end
      total++;
      if (bus4.o_last !== (k == 3) || bus4.o_nonce !== 7'h2A) begin
        bad++;
        $display("FAIL single_last_nonce%0d: last=%b nonce=%h want %b 2a",
                 k, bus4.o_last, bus4.o_nonce, (k == 3));
      end
    end
    @(negedge clk);
    total++;
    if (bus4.o_sh_valid !== 1'b0 || bus4.o_sh_data !== 128'd0 || bus4.o_ex_handshake !== 1'b0) begin
      bad++;
      $display("FAIL single_empty: valid=%b data=%h hs=%b want 0 0 0",
               bus4.o_sh_valid, bus4.o_sh_data, bus4.o_ex_handshake);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] base = 64'hA0;
    bus4.i_ex_data  = mk_blk4(base);
    bus4.i_nonce    = 7'h11;
    bus4.i_ex_valid = 1'b1;
    bus4.i_sh_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) bus4.i_ex_valid = 1'b0;
      total++;
      if (bus4.o_beat !== 2'(k) || bus4.o_sh_data !== exp_beat4(base, k)) begin
        bad++;
        $display("FAIL bp_beat%0d: beat=%0d data=%h want %0d %h",
                 k, bus4.o_beat, bus4.o_sh_data, k, exp_beat4(base, k));
      end
    end
    bus4.i_sh_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus4.o_sh_valid !== 1'b1 || bus4.o_beat !== 2'd2 ||
          bus4.o_sh_data !== exp_beat4(base, 2) || bus4.o_last !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b beat=%0d data=%h last=%b want 1 2 %h 0",
                 c, bus4.o_sh_valid, bus4.o_beat, bus4.o_sh_data, bus4.o_last, exp_beat4(base, 2));
      end
    end
    bus4.i_sh_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus4.o_beat !== 2'd3 || bus4.o_last !== 1'b1 || bus4.o_sh_data !== exp_beat4(base, 3)) begin
      bad++;
      $display("FAIL bp_resume: beat=%0d last=%b data=%h want 3 1 %h",
               bus4.o_beat, bus4.o_last, bus4.o_sh_data, exp_beat4(base, 3));
    end
    @(negedge clk);
    total++;
    if (bus4.o_sh_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_empty: valid=%b want 0", bus4.o_sh_valid);
    end
  endtask

  task automatic test_four_phase();
    int hs_low = 0;
    int n = 0;
    bus4.i_sh_ready = 1'b0;
    bus4.i_ex_data  = mk_blk4(64'h50);
    bus4.i_nonce    = 7'h05;
    bus4.i_ex_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus4.o_ex_handshake !== 1'b1) hs_low++;
    end
    total++;
    if (hs_low != 0) begin
      bad++;
      $display("FAIL fp_hs_held: low_cycles=%0d want 0", hs_low);
    end
    bus4.i_ex_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus4.o_ex_handshake !== 1'b0) begin
      bad++;
      $display("FAIL fp_hs_drop: got %b want 0", bus4.o_ex_handshake);
    end
    bus4.i_sh_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus4.o_sh_valid) n++;
      @(negedge clk);
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL fp_one_capture: beats=%0d want 4", n);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] bases [3];
    logic [6:0]  nonces [3];
    bit ok;
    int hs_seen = 0;
    bases[0] = 64'h100; bases[1] = 64'h200; bases[2] = 64'h300;
    nonces[0] = 7'h01;  nonces[1] = 7'h02;  nonces[2] = 7'h03;
    bus4.i_sh_ready = 1'b0;
    offer4(mk_blk4(bases[0]), nonces[0], ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_capture_a: handshake=0 want 1"); end
    offer4(mk_blk4(bases[1]), nonces[1], ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_capture_b: handshake=0 want 1"); end
    bus4.i_ex_data  = mk_blk4(bases[2]);
    bus4.i_nonce    = nonces[2];
    bus4.i_ex_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus4.o_ex_handshake) hs_seen++;
    end
    total++;
    if (hs_seen != 0) begin
      bad++;
      $display("FAIL b2b_full_no_ack: hs_cycles=%0d want 0", hs_seen);
    end
    bus4.i_sh_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (bus4.o_sh_valid !== 1'b1 || bus4.o_beat !== 2'(i % 4) ||
          bus4.o_sh_data !== exp_beat4(bases[i/4], i % 4) || bus4.o_nonce !== nonces[i/4]) begin
        bad++;
        $display("FAIL b2b_beat%0d: valid=%b beat=%0d data=%h nonce=%h want 1 %0d %h %h",
                 i, bus4.o_sh_valid, bus4.o_beat, bus4.o_sh_data, bus4.o_nonce,
                 i % 4, exp_beat4(bases[i/4], i % 4), nonces[i/4]);
      end
      if (bus4.o_ex_handshake) bus4.i_ex_valid = 1'b0;
      @(negedge clk);
    end
    total++;
    if (bus4.o_sh_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_empty: valid=%b want 0", bus4.o_sh_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [63:0] base_a = 64'h700;
    logic [63:0] base_d = 64'h900;
    bus4.i_ex_data  = mk_blk4(base_a);
    bus4.i_nonce    = 7'h33;
    bus4.i_ex_valid = 1'b1;
    bus4.i_sh_ready = 1'b1;
    @(negedge clk);
    bus4.i_ex_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus4.o_beat !== 2'd1 || bus4.o_sh_data !== exp_beat4(base_a, 1)) begin
      bad++;
      $display("FAIL rmd_beat1: beat=%0d data=%h want 1 %h",
               bus4.o_beat, bus4.o_sh_data, exp_beat4(base_a, 1));
    end
    bus4.i_ex_data  = mk_blk4(base_d);
    bus4.i_nonce    = 7'h44;
    bus4.i_ex_valid = 1'b1;
    rst = 1'b1;
    #1;
    total++;
    if ({bus4.o_sh_valid, bus4.o_ex_handshake, bus4.o_last} !== 3'b000 ||
        bus4.o_sh_data !== 128'd0 || bus4.o_beat !== 2'd0 || bus4.o_nonce !== 7'd0) begin
      bad++;
      $display("FAIL rmd_async_clear: v/hs/last=%b data=%h beat=%0d nonce=%h want 0",
               {bus4.o_sh_valid, bus4.o_ex_handshake, bus4.o_last},
               bus4.o_sh_data, bus4.o_beat, bus4.o_nonce);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus4.o_sh_valid !== 1'b1 || bus4.o_beat !== 2'd0 || bus4.o_ex_handshake !== 1'b1 ||
        bus4.o_sh_data !== exp_beat4(base_d, 0) || bus4.o_nonce !== 7'h44) begin
      bad++;
      $display("FAIL rmd_recapture: valid=%b beat=%0d hs=%b data=%h nonce=%h want 1 0 1 %h 44",
               bus4.o_sh_valid, bus4.o_beat, bus4.o_ex_handshake, bus4.o_sh_data,
               bus4.o_nonce, exp_beat4(base_d, 0));
    end
    bus4.i_ex_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (bus4.o_sh_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmd_drained: valid=%b want 0", bus4.o_sh_valid);
    end
  endtask

  task automatic test_nbeat8();
    logic [511:0] blk;
    logic [31:0]  lo;
    logic [31:0]  hi;
    for (int i = 0; i < 16; i++) blk[i*32 +: 32] = 32'h1000 + 32'(i);
    bus8.i_ex_data  = blk;
    bus8.i_nonce    = 7'h7F;
    bus8.i_ex_valid = 1'b1;
    bus8.i_sh_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) bus8.i_ex_valid = 1'b0;
      lo = 32'h1000 + 32'(k);
      hi = 32'h1008 + 32'(k);
      total++;
      if (bus8.o_sh_valid !== 1'b1 || bus8.o_beat !== 3'(k) || bus8.o_sh_data !== {lo, hi} ||
          bus8.o_last !== (k == 7) || bus8.o_nonce !== 7'h7F) begin
        bad++;
        $display("FAIL nb8_beat%0d: valid=%b beat=%0d data=%h last=%b nonce=%h want 1 %0d %h %b 7f",
                 k, bus8.o_sh_valid, bus8.o_beat, bus8.o_sh_data, bus8.o_last,
                 bus8.o_nonce, k, {lo, hi}, (k == 7));
      end
    end
    @(negedge clk);
    total++;
    if (bus8.o_sh_valid !== 1'b0 || bus8.o_sh_data !== 64'd0) begin
      bad++;
      $display("FAIL nb8_empty: valid=%b data=%h want 0 0", bus8.o_sh_valid, bus8.o_sh_data);
    end
  endtask

`ifdef SHUFFLE_LOADER_STALL_CNT_EN
  task automatic test_stall_cnt();
    reset_dut();
    bus4.i_ex_data  = mk_blk4(64'h20);
    bus4.i_nonce    = 7'h01;
    bus4.i_ex_valid = 1'b1;
    bus4.i_sh_ready = 1'b0;
    @(negedge clk);
    bus4.i_ex_valid = 1'b0;
    total++;
    if (bus4.o_sh_valid !== 1'b1 || bus4.o_stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL stall_start: valid=%b cnt=%0d want 1 0", bus4.o_sh_valid, bus4.o_stall_cnt);
    end
    repeat (10) @(negedge clk);
    total++;
    if (bus4.o_stall_cnt !== 16'd10) begin
      bad++;
      $display("FAIL stall_10: cnt=%0d want 10", bus4.o_stall_cnt);
    end
    bus4.i_sh_ready = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (bus4.o_sh_valid !== 1'b0 || bus4.o_stall_cnt !== 16'd10) begin
      bad++;
      $display("FAIL stall_after_drain: valid=%b cnt=%0d want 0 10",
               bus4.o_sh_valid, bus4.o_stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_four_phase();
    test_back_to_back();
    test_reset_mid_drain();
    test_nbeat8();
`ifdef SHUFFLE_LOADER_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
